// File: rtl/mac_pkg.sv
// Shared types and constants for the MAC array feeders.
// The feeder FSM states, the lane geometry and the lane bit-slice helper all live here.
package mac_pkg;

  localparam int LANES     = 4;
  localparam int SEG_W_DEF = 16;
  localparam int SEGS      = 4;

  typedef enum logic [2:0] {IDLE, FETCH, WAIT, STREAM, DONE} state_t;

  // LSB of lane r inside a packed LANES*seg_w bus; lane 0 sits in the top slice.
  function automatic int lane_lsb(input int lane, input int seg_w);
    return (LANES - 1 - lane) * seg_w;
  endfunction

endpackage

// File: rtl/input_lane_shifter.sv
// One lane's row register.
// It loads a full row word, then shifts left by one segment per accepted beat; the output is the top segment.
module input_lane_shifter
  import mac_pkg::*;
#(
  parameter int SEG_W = SEG_W_DEF
) (
  input  logic                  CLK,
  input  logic                  RSTN,
  input  logic                  load,
  input  logic                  shift,
  input  logic [SEGS*SEG_W-1:0] din,
  output logic [SEG_W-1:0]      dout
);

  localparam int ROW_W = SEGS * SEG_W;

  logic [ROW_W-1:0] row_p0;

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      row_p0 <= '0;
    end else if (load) begin
      row_p0 <= din;
    end else if (shift) begin
      row_p0 <= {row_p0[ROW_W-SEG_W-1:0], {SEG_W{1'b0}}};
    end
  end

  assign dout = row_p0[ROW_W-1 -: SEG_W];

endmodule

// File: rtl/input_stage.sv
// Tile feeder: fetches four row words from input memory and streams them into the MAC array.
// Define INPUT_STAGE_SKEW_EN for the systolic (one cycle per lane) wavefront; otherwise all lanes stream together.
module input_stage
  import mac_pkg::*;
#(
  parameter int AW    = 4,
  parameter int SEG_W = SEG_W_DEF
) (
  input  logic                  CLK,
  input  logic                  RSTN,
  input  logic                  Tile_Start,
  input  logic [AW-1:0]         ISRC_i,
  output logic                  IMEM_Read,
  output logic [AW-1:0]         IMEM_Addr,
  input  logic [SEGS*SEG_W-1:0] IMEM_Data,
  input  logic                  MAC_IREADY,
  output logic [SEGS*SEG_W-1:0] MAC_IDATA,
  output logic [LANES-1:0]      MAC_IVALID,
  output logic                  Busy,
  output logic                  Tile_Done
);

`ifdef INPUT_STAGE_SKEW_EN
  localparam logic [2:0] T_LAST = 3'd6;
`else
  localparam logic [2:0] T_LAST = 3'd3;
`endif

  state_t             state_p0;
  state_t             state_nxt;
  logic [1:0]         rd_idx_p0;
  logic               cap_vld_p1;
  logic [1:0]         cap_idx_p1;
  logic [2:0]         t_p0;
  logic [LANES-1:0]   lane_vld;
  logic [LANES-1:0]   lane_load;
  logic [LANES-1:0]   lane_shift;
  logic [SEG_W-1:0]   lane_seg [LANES];

  always_ff @(posedge CLK) begin
    if (!RSTN) state_p0 <= IDLE;
    else       state_p0 <= state_nxt;
  end

  always_comb begin
    state_nxt = state_p0;
    Busy      = 1'b1;
    Tile_Done = 1'b0;
    case (state_p0)
      IDLE: begin
        Busy = 1'b0;
        if (Tile_Start) state_nxt = FETCH;
      end
      FETCH:   if (rd_idx_p0 == 2'd3) state_nxt = WAIT;
      WAIT:    state_nxt = STREAM;
      STREAM:  if (MAC_IREADY && (t_p0 == T_LAST)) state_nxt = DONE;
      DONE: begin
        Tile_Done = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Read issue (p0) and capture of the returning word one cycle later (p1)
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      IMEM_Read  <= 1'b0;
      IMEM_Addr  <= '0;
      rd_idx_p0  <= '0;
      cap_vld_p1 <= 1'b0;
      cap_idx_p1 <= '0;
    end else begin
      cap_vld_p1 <= IMEM_Read;
      cap_idx_p1 <= rd_idx_p0;
      case (state_p0)
        IDLE: begin
          if (Tile_Start) begin
            IMEM_Read <= 1'b1;
            IMEM_Addr <= ISRC_i;
            rd_idx_p0 <= '0;
          end
        end
        FETCH: begin
          if (rd_idx_p0 == 2'd3) begin
            IMEM_Read <= 1'b0;
          end else begin
            IMEM_Addr <= IMEM_Addr + AW'(1);
            rd_idx_p0 <= rd_idx_p0 + 2'd1;
          end
        end
        default: IMEM_Read <= 1'b0;
      endcase
    end
  end

  // Stream beat counter; holds while the array stalls
  always_ff @(posedge CLK) begin
    if (!RSTN || (state_p0 != STREAM)) begin
      t_p0 <= '0;
    end else if (MAC_IREADY && (t_p0 != T_LAST)) begin
      t_p0 <= t_p0 + 3'd1;
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
`ifdef INPUT_STAGE_SKEW_EN
    localparam logic [2:0] T_LO = 3'(g);
    localparam logic [2:0] T_HI = 3'(g + 3);
    assign lane_vld[g] = (state_p0 == STREAM) && (t_p0 >= T_LO) && (t_p0 <= T_HI);
`else
    assign lane_vld[g] = (state_p0 == STREAM) && (t_p0 <= 3'd3);
`endif
    assign lane_load[g]  = cap_vld_p1 && (cap_idx_p1 == 2'(g));
    assign lane_shift[g] = lane_vld[g] && MAC_IREADY;

    input_lane_shifter #(.SEG_W(SEG_W)) u_shifter (
      .CLK   (CLK),
      .RSTN  (RSTN),
      .load  (lane_load[g]),
      .shift (lane_shift[g]),
      .din   (IMEM_Data),
      .dout  (lane_seg[g])
    );
  end

  always_comb begin
    MAC_IDATA  = '0;
    MAC_IVALID = lane_vld;
    for (int r = 0; r < LANES; r++) begin
      if (lane_vld[r]) MAC_IDATA[lane_lsb(r, SEG_W) +: SEG_W] = lane_seg[r];
    end
  end

endmodule

// File: tb/tb_input_stage.sv
// Bench for input_stage: table of tile scenarios, per-cycle expectations queued at start and checked at negedge.
module tb_input_stage;

`ifdef INPUT_STAGE_SKEW_EN
  localparam bit SKEW = 1'b1;
  localparam int LAST = 6;
`else
  localparam bit SKEW = 1'b0;
  localparam int LAST = 3;
`endif

  logic        CLK, RSTN, Tile_Start, IMEM_Read, MAC_IREADY, Busy, Tile_Done;
  logic [3:0]  ISRC_i, IMEM_Addr, MAC_IVALID;
  logic [63:0] IMEM_Data, MAC_IDATA;

  input_stage #(.AW(4), .SEG_W(16)) dut (
    .CLK        (CLK),
    .RSTN       (RSTN),
    .Tile_Start (Tile_Start),
    .ISRC_i     (ISRC_i),
    .IMEM_Read  (IMEM_Read),
    .IMEM_Addr  (IMEM_Addr),
    .IMEM_Data  (IMEM_Data),
    .MAC_IREADY (MAC_IREADY),
    .MAC_IDATA  (MAC_IDATA),
    .MAC_IVALID (MAC_IVALID),
    .Busy       (Busy),
    .Tile_Done  (Tile_Done)
  );

  typedef struct {
    int          cyc;
    bit          rd;
    logic [3:0]  addr;
    logic [3:0]  vld;
    logic [63:0] data;
    bit          busy;
    bit          done;
  } exp_t;

  typedef struct {
    int base;
    int s0;
    int n;
    int busy_rc;
    int abort_rc;
    int done_rc;
  } vec_t;

  exp_t        q[$];
  vec_t        vecs[7];
  logic [63:0] mem [16];
  int          n_chk, n_pass, cyc, done_cyc, done_cnt;
  bit          mon_en;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  always @(posedge CLK) begin
    if (IMEM_Read) IMEM_Data <= mem[IMEM_Addr];
    else           IMEM_Data <= {$urandom, $urandom};
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
  endtask

  always @(negedge CLK) begin
    exp_t e;
    logic [127:0] a, x;
    if (mon_en) begin
      if (Tile_Done === 1'b1) begin
        done_cyc = cyc;
        done_cnt++;
      end
      e = '{cyc: cyc, rd: 1'b0, addr: 4'd0, vld: 4'd0, data: 64'd0, busy: 1'b0, done: 1'b0};
      if (q.size() > 0 && q[0].cyc == cyc) e = q.pop_front();
      a = {53'd0, IMEM_Read, (IMEM_Read === 1'b1) ? IMEM_Addr : 4'd0, MAC_IVALID, MAC_IDATA, Busy, Tile_Done};
      x = {53'd0, e.rd, e.rd ? e.addr : 4'd0, e.vld, e.data, e.busy, e.done};
      chk("cycle_outputs", a, x);
    end
  end

  function automatic int stalled_before(input int rc, input int s0, input int n);
    int k;
    if (n == 0 || rc <= s0) return 0;
    k = rc - s0;
    return (k > n) ? n : k;
  endfunction

  task automatic gen_tile(input vec_t v, input int c0, output int done_rc);
    exp_t e;
    int t, seg, lim, last_cyc;
    logic [63:0] row;
    last_cyc = 6 + LAST + ((v.n > 0 && 6 + LAST >= v.s0) ? v.n : 0);
    done_rc = last_cyc + 1;
    lim = (v.abort_rc > 0) ? v.abort_rc : done_rc;
    for (int rc = 1; rc <= lim; rc++) begin
      e = '{cyc: c0 + rc, rd: (rc <= 4), addr: 4'(v.base + rc - 1), vld: 4'd0, data: 64'd0,
            busy: 1'b1, done: (rc == done_rc)};
      if (rc >= 6 && rc < done_rc) begin
        t = rc - 6 - stalled_before(rc, v.s0, v.n);
        for (int r = 0; r < 4; r++) begin
          seg = SKEW ? (t - r) : t;
          if (seg >= 0 && seg <= 3) begin
            row = mem[(v.base + r) % 16];
            e.vld[r] = 1'b1;
            e.data[63 - 16*r -: 16] = row[63 - 16*seg -: 16];
          end
        end
      end
      q.push_back(e);
    end
  endtask

  task automatic do_tile(input vec_t v);
    int c0, done_rc, lim;
    bit in_stream;
    @(posedge CLK); #1;
    c0 = cyc;
    done_cyc = -1;
    done_cnt = 0;
    Tile_Start = 1'b1;
    ISRC_i = 4'(v.base);
    MAC_IREADY = 1'($urandom);
    gen_tile(v, c0, done_rc);
    lim = (v.abort_rc > 0) ? v.abort_rc + 1 : done_rc;
    for (int rc = 1; rc <= lim; rc++) begin
      @(posedge CLK); #1;
      Tile_Start = (rc == v.busy_rc);
      ISRC_i = 4'($urandom);
      RSTN = !(rc == v.abort_rc);
      in_stream = (rc >= 6 && rc < done_rc);
      if (in_stream) MAC_IREADY = !(v.n > 0 && rc >= v.s0 && rc < v.s0 + v.n);
      else           MAC_IREADY = 1'($urandom);
    end
    Tile_Start = 1'b0;
    @(negedge CLK); #1;
    chk("done_cycle", (done_cyc >= 0) ? done_cyc - c0 : -1, v.done_rc);
    chk("done_count", done_cnt, (v.done_rc >= 0) ? 1 : 0);
    if (v.abort_rc > 0) chk("abort_addr_reset", IMEM_Addr, 4'd0);
    q.delete();
  endtask

  initial begin
    for (int a = 0; a < 16; a++) mem[a] = 64'h0001_0002_0003_0004 + 64'(a) * 64'h1000_1000_1000_1000;
    n_chk = 0; n_pass = 0; mon_en = 1'b0;
    done_cyc = -1; done_cnt = 0;
    RSTN = 1'b0; Tile_Start = 1'b1; ISRC_i = 4'h5; MAC_IREADY = 1'b1;

    vecs[0] = '{base: 0,  s0: 0, n: 0, busy_rc: 0, abort_rc: 0, done_rc: SKEW ? 13 : 10};
    vecs[1] = '{base: 14, s0: 0, n: 0, busy_rc: 0, abort_rc: 0, done_rc: SKEW ? 13 : 10};
    vecs[2] = '{base: 0,  s0: 8, n: 2, busy_rc: 0, abort_rc: 0, done_rc: SKEW ? 15 : 12};
    vecs[3] = '{base: 3,  s0: 0, n: 0, busy_rc: 7, abort_rc: 0, done_rc: SKEW ? 13 : 10};
    vecs[4] = '{base: 0,  s0: 0, n: 0, busy_rc: 0, abort_rc: 8, done_rc: -1};
    vecs[5] = '{base: 0,  s0: 0, n: 0, busy_rc: 0, abort_rc: 0, done_rc: SKEW ? 13 : 10};
    vecs[6] = '{base: 5,  s0: 7, n: 3, busy_rc: 0, abort_rc: 0, done_rc: SKEW ? 16 : 13};

    // Reset held with Tile_Start high: must stay idle with reset values.
    @(posedge CLK); #1;
    mon_en = 1'b1;
    repeat (2) begin
      @(posedge CLK); #1;
    end
    chk("reset_addr", IMEM_Addr, 4'd0);
    RSTN = 1'b1;
    Tile_Start = 1'b0;
    repeat (2) begin
      @(posedge CLK); #1;
      MAC_IREADY = 1'($urandom);
    end

    for (int i = 0; i < 7; i++) do_tile(vecs[i]);

    // Idle tail with ready toggling: nothing may move.
    repeat (4) begin
      @(posedge CLK); #1;
      MAC_IREADY = 1'($urandom);
      ISRC_i = 4'($urandom);
    end
    @(negedge CLK); #1;
    mon_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/input_stage.md
# input_stage

Tile feeder on the read side of the MAC array, the mirror of the output collector. On a start request it fetches four 64-bit row words from input memory, one per lane. It then streams each row into the MAC array as four 16-bit segments, most-significant segment first. Lane r starts r cycles after lane 0, forming the systolic wavefront. It reports busy while working and pulses done when the tile has fully drained.

## Interface
- AW, 4, input-memory address width; addresses wrap modulo 2^AW
- SEG_W, 16, segment width; row word = 4*SEG_W bits
- CLK  in  1  clock; all logic on rising edge
- RSTN  in  1  synchronous active-low reset
- Tile_Start  in  1  start request; sampled only in IDLE
- ISRC_i  in  AW  tile base address; latched on accepted Tile_Start
- IMEM_Read  out  1  read strobe, registered
- IMEM_Addr  out  AW  read address, registered
- IMEM_Data  in  4*SEG_W  read data, valid exactly 1 cycle after IMEM_Read
- MAC_IREADY  in  1  array accepts data; low = stall
- MAC_IDATA  out  4*SEG_W  lane r occupies bits [4*SEG_W-1-r*SEG_W -: SEG_W]
- MAC_IVALID  out  4  per-lane valid
- Busy  out  1  high from the cycle after start acceptance through the Tile_Done cycle
- Tile_Done  out  1  one-cycle pulse after the last segment is accepted

## Operation
- States: IDLE, FETCH, WAIT, STREAM, DONE.
- IDLE: if Tile_Start, latch base = ISRC_i and go to FETCH; otherwise hold.
- FETCH: 4 cycles; IMEM_Read=1, IMEM_Addr = base+k for k=0..3 (mod 2^AW); then go to WAIT.
- Capture: the word returned for read k loads row_buf[k].
- WAIT: 1 cycle, until row_buf[3] is loaded; then go to STREAM with stream counter t=0.
- STREAM: lane r is valid when r <= t <= r+3. Its segment index is t-r, with segment 0 = row bits [4*SEG_W-1 -: SEG_W].
- STREAM lane data: invalid lanes drive 0.
- STREAM advance: t increments only when MAC_IREADY=1. Leave STREAM when t=6 is accepted.
- DONE: 1 cycle; Tile_Done=1, Busy=1; then go to IDLE.
- Stall: with MAC_IREADY=0, MAC_IDATA, MAC_IVALID and t hold exactly. MAC_IREADY has no effect outside STREAM.
- Tile_Start outside IDLE is ignored; it is not queued.
- Reset: synchronous, including mid-tile. The next edge with RSTN=0 forces IDLE and abandons the tile without a Tile_Done pulse.
- Reset values: IMEM_Read=0, IMEM_Addr=0, MAC_IDATA=0, MAC_IVALID=0, Busy=0, Tile_Done=0, row_buf=0, t=0.

## Timing
- Tile_Start sampled high at the end of cycle 0.
- FETCH runs cycles 1–4.
- IMEM_Data is captured in cycles 2–5; WAIT is cycle 5.
- STREAM runs cycles 6–12 with no stall; lane r is valid in cycles 6+r..9+r.
- DONE is cycle 13; the earliest next start is sampled in cycle 14.
- Busy is high in cycles 1–13.
- Each stall cycle delays everything after it by one cycle.
- Total tile latency without stall: 13 cycles from start acceptance to Tile_Done.

## Configuration
- INPUT_STAGE_SKEW_EN defined: skewed wavefront as above; STREAM lasts 7 accepted cycles (t=0..6).
- INPUT_STAGE_SKEW_EN undefined: no skew; all four lanes are valid together for t=0..3; STREAM lasts 4 accepted cycles; Tile_Done falls in cycle 10 with no stall.

## Structure
- Shared package mac_pkg holds:
  - state enum (IDLE, FETCH, WAIT, STREAM, DONE)
  - LANES=4, SEG_W default, segments-per-row = 4
  - lane bit-slice helper
- One sub-module, input_lane_shifter:
  - per-lane 4*SEG_W register with load, shift-left-by-SEG_W and hold controls
  - output is its top SEG_W bits
  - instantiated 4 times; the top level owns the FSM, the address counter and the skew enables.

## Test plan
- Basic tile: memory rows 0..3 = 0x0001_0002_0003_0004 + r*0x1000_1000_1000_1000, ISRC_i=0, MAC_IREADY=1. Expect:
  - reads at addresses 0..3 in cycles 1–4
  - lane 0 emits 0x0001, 0x0002, 0x0003, 0x0004 in cycles 6–9
  - lane 3 emits 0x3001..0x3004 in cycles 9–12
  - Tile_Done in cycle 13
- Address wrap: ISRC_i=0xE. Reads at 0xE, 0xF, 0x0, 0x1; lane order follows the read order.
- Stall: MAC_IREADY=0 for cycles 8–9. Outputs of cycle 8 hold through cycle 10, then resume; Tile_Done moves to cycle 15.
- Start while busy: Tile_Start pulsed in cycle 7. No extra reads occur; only one Tile_Done.
- Reset mid-stream: RSTN=0 in cycle 8. All outputs are 0 from cycle 9, state is IDLE, no Tile_Done; a new start behaves like the basic tile.
- Skew disabled (INPUT_STAGE_SKEW_EN undefined): MAC_IVALID=4'b1111 in cycles 6–9 and Tile_Done in cycle 10.
